// File: rtl/freq_div_scheduler.sv
// Round-robin scheduler sharing one divider among N_CH period channels; issues CLOCK_FREQ/period.
// Ack 1 cycle after grant; freq_valid 2 cycles after div_ready, or after a zero period or timeout.
// Requests are level-held until ch_ack; the divider is trusted, with a WAIT timeout as the only guard.
`timescale 1ns/1ps
module freq_div_scheduler #(
    parameter int          N_CH        = 4,
    parameter int          CH_W        = 2,
    parameter logic [31:0] CLOCK_FREQ  = 32'd50_000_000,
    parameter int          DIV_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      ch_req,
    input  logic [32*N_CH-1:0]   ch_period,
    output logic [N_CH-1:0]      ch_ack,
    output logic                 div_start,
    output logic [31:0]          div_dividend,
    output logic [31:0]          div_divisor,
    input  logic [31:0]          div_quotient,
    input  logic                 div_ready,
    output logic                 freq_valid,
    output logic [31:0]          freq_out,
    output logic [CH_W-1:0]      freq_ch,
    output logic                 freq_err,
    output logic                 busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ISSUE  = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] OUTPUT = 2'd3;

    localparam int            TW       = $clog2(DIV_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(DIV_TIMEOUT - 1);

    logic [1:0]      state;
    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] gnt_q;
    logic [31:0]     period_q;
    logic [31:0]     res_q;
    logic            err_q;
    logic [TW-1:0]   tmo_cnt;

    logic            gnt_found;
    logic [CH_W-1:0] gnt_idx;
    logic [31:0]     gnt_period;
    logic [CH_W-1:0] ptr_next;

    // Scan channels starting at ptr so the most recently served channel is last in line.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < N_CH; i++) begin
            int c;
            logic [CH_W-1:0] cc;
            c = int'(ptr) + i;
            if (c >= N_CH) c = c - N_CH;
            cc = CH_W'(c);
            if (!gnt_found && ch_req[cc]) begin
                gnt_found = 1'b1;
                gnt_idx   = cc;
            end
        end
        gnt_period = ch_period[32*int'(gnt_idx) +: 32];
        ptr_next   = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            ptr          <= '0;
            gnt_q        <= '0;
            period_q     <= '0;
            res_q        <= '0;
            err_q        <= 1'b0;
            tmo_cnt      <= '0;
            ch_ack       <= '0;
            div_start    <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            freq_valid   <= 1'b0;
            freq_out     <= '0;
            freq_ch      <= '0;
            freq_err     <= 1'b0;
        end else begin
            ch_ack     <= '0;
            div_start  <= 1'b0;
            freq_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        gnt_q        <= gnt_idx;
                        period_q     <= gnt_period;
                        ptr          <= ptr_next;
                        ch_ack       <= N_CH'(1) << gnt_idx;
                        div_start    <= (gnt_period != 32'd0);
                        div_dividend <= CLOCK_FREQ;
                        div_divisor  <= gnt_period;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    tmo_cnt <= '0;
                    if (period_q == 32'd0) begin
                        res_q <= '0;
                        err_q <= 1'b1;
                        state <= OUTPUT;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // A result arriving on the final allowed cycle still beats the timeout.
                    if (div_ready) begin
                        res_q <= div_quotient;
                        err_q <= 1'b0;
                        state <= OUTPUT;
                    end else if (tmo_cnt == TMO_LAST) begin
                        res_q <= '0;
                        err_q <= 1'b1;
                        state <= OUTPUT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                OUTPUT: begin
                    freq_valid <= 1'b1;
                    freq_out   <= res_q;
                    freq_err   <= err_q;
                    freq_ch    <= gnt_q;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_div_scheduler.sv
// Randomized bench for freq_div_scheduler with a round-robin reference model and result scoreboard.
`timescale 1ns/1ps
module tb_freq_div_scheduler;

    localparam int          N     = 4;
    localparam logic [31:0] CLK_F = 32'd50_000_000;
    localparam int          TMO   = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     ch_req;
    logic [32*N-1:0]  ch_period;
    logic [N-1:0]     ch_ack;
    logic             div_start;
    logic [31:0]      div_dividend;
    logic [31:0]      div_divisor;
    logic [31:0]      div_quotient;
    logic             div_ready;
    logic             freq_valid;
    logic [31:0]      freq_out;
    logic [1:0]       freq_ch;
    logic             freq_err;
    logic             busy;

    logic [31:0] per_arr [N];
    assign ch_period = {per_arr[3], per_arr[2], per_arr[1], per_arr[0]};

    always #5 clk = ~clk;

    freq_div_scheduler #(.N_CH(N), .CH_W(2), .CLOCK_FREQ(CLK_F), .DIV_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .ch_req(ch_req), .ch_period(ch_period), .ch_ack(ch_ack),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_ready(div_ready), .freq_valid(freq_valid),
        .freq_out(freq_out), .freq_ch(freq_ch), .freq_err(freq_err), .busy(busy)
    );

    typedef struct {
        int          ch;
        logic [31:0] val;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   mptr   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arbiter: first requester at or after the pointer, wrapping modulo N.
    function automatic int model_grant(input logic [N-1:0] req);
        for (int i = 0; i < N; i++)
            if (req[(mptr + i) % N]) return (mptr + i) % N;
        return 0;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (freq_valid) begin
            if (sb.size() == 0) begin
                chk("fv_unexpected", 32'(freq_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("fv_ch",  32'(freq_ch),  32'(e.ch));
                chk("fv_out", freq_out,      e.val);
                chk("fv_err", 32'(freq_err), 32'(e.err));
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst_ack",      32'(ch_ack),     32'd0);
        chk("rst_start",    32'(div_start),  32'd0);
        chk("rst_dividend", div_dividend,    32'd0);
        chk("rst_divisor",  div_divisor,     32'd0);
        chk("rst_fv",       32'(freq_valid), 32'd0);
        chk("rst_fout",     freq_out,        32'd0);
        chk("rst_fch",      32'(freq_ch),    32'd0);
        chk("rst_ferr",     32'(freq_err),   32'd0);
        chk("rst_busy",     32'(busy),       32'd0);
    endtask

    task automatic wait_ack(output int g, output logic [31:0] per);
        int n;
        logic [N-1:0] onehot;
        g      = model_grant(ch_req);
        per    = per_arr[g];
        onehot = '0;
        onehot[g] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ch_ack == '0 && n < 20);
        chk("ack_grant",    32'(ch_ack),    32'(onehot));
        chk("div_start",    32'(div_start), 32'(per != 32'd0));
        chk("div_divisor",  div_divisor,    per);
        chk("div_dividend", div_dividend,   CLK_F);
        mptr = (g + 1) % N;
    endtask

    task automatic wait_fv(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!freq_valid && n < 200);
    endtask

    // mode 0: divider answers after a random delay; mode 2: divider never answers.
    task automatic serve(input bit drop, input int mode);
        int g, n, d;
        logic [31:0] per;
        wait_ack(g, per);
        if (drop) ch_req[g] = 1'b0;
        if (per == 32'd0) begin
            sb.push_back('{g, 32'd0, 1'b1});
            wait_fv(n);
            chk("lat_zero", 32'(n), 32'd2);
        end else if (mode == 2) begin
            sb.push_back('{g, 32'd0, 1'b1});
            wait_fv(n);
            chk("lat_timeout", 32'(n), 32'(TMO + 2));
        end else begin
            sb.push_back('{g, CLK_F / per, 1'b0});
            d = $urandom_range(0, 8);
            repeat (1 + d) @(negedge clk);
            div_ready    = 1'b1;
            div_quotient = CLK_F / per;
            @(negedge clk);
            div_ready    = 1'b0;
            div_quotient = $urandom;
            chk("fv_early", 32'(freq_valid), 32'd0);
            wait_fv(n);
            chk("lat_ready", 32'(n + 1), 32'd2);
        end
    endtask

    initial begin
        int g;
        logic [31:0] per;
        logic [N-1:0] mask;
        rst = 1'b0;
        ch_req = '0;
        div_ready = 1'b0;
        div_quotient = '0;
        for (int i = 0; i < N; i++) per_arr[i] = 32'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b1;
        @(negedge clk);

        // Single channel, exact values.
        per_arr[1] = 32'd50000;
        ch_req = 4'b0010;
        serve(1'b1, 0);

        // Stray divider result while idle.
        div_ready = 1'b1;
        div_quotient = 32'd7;
        repeat (3) begin
            @(negedge clk);
            chk("stray_busy", 32'(busy), 32'd0);
        end
        div_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Zero period on channel 2.
        per_arr[2] = 32'd0;
        ch_req = 4'b0100;
        serve(1'b1, 0);

        // Divider timeout, late result ignored, then normal service.
        per_arr[0] = 32'd20000;
        ch_req = 4'b0001;
        serve(1'b1, 2);
        div_ready = 1'b1;
        div_quotient = 32'd999;
        @(negedge clk);
        div_ready = 1'b0;
        repeat (4) @(negedge clk);
        chk("late_busy", 32'(busy), 32'd0);
        ch_req = 4'b0001;
        serve(1'b1, 0);

        // Reset in the middle of WAIT; pointer must return to channel 0.
        per_arr[1] = 32'd1234;
        ch_req = 4'b0010;
        wait_ack(g, per);
        ch_req = '0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        mptr = 0;
        rst = 1'b1;
        div_ready = 1'b1;
        div_quotient = 32'd4321;
        @(negedge clk);
        div_ready = 1'b0;
        repeat (3) @(negedge clk);
        per_arr[0] = 32'd1000;
        per_arr[2] = 32'd3000;
        ch_req = 4'b0101;
        serve(1'b1, 0);
        serve(1'b1, 0);

        // All channels held: strict rotation.
        per_arr[0] = 32'd100;
        per_arr[1] = 32'd777;
        per_arr[2] = 32'd25;
        per_arr[3] = 32'd0;
        ch_req = 4'b1111;
        repeat (8) serve(1'b0, 0);
        ch_req = '0;
        repeat (3) @(negedge clk);

        // Random request masks and periods.
        repeat (30) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++)
                per_arr[i] = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 100000));
            ch_req = mask;
            repeat ($countones(mask)) serve(1'b1, ($urandom_range(0, 15) == 0) ? 2 : 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
